// File: rtl/countdown_pkg.sv
// Shared state encodings and default sizing for the countdown sequencer.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_TICK_DIV = 4;

endpackage

// File: rtl/countdown_sequencer_dec_unit.sv
// Combinational WIDTH-bit decrementer (y = a - 1) used as the countdown datapath.
module dec_unit
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = a - 1'b1;

endmodule

// File: rtl/countdown_sequencer.sv
// Programmable countdown timer: one decrement every TICK_DIV cycles, with pause/abort and a done pulse.
// Optional auto-reload when COUNTDOWN_AUTO_RELOAD_EN is defined.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] dec_y;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  dec_unit #(.WIDTH(WIDTH)) u_dec (
    .a (count_q),
    .y (dec_y)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (abort) begin
          count_d = '0;
        end else if (load) begin
          count_d = load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          reload_d = load_value;
`endif
        end else if (start) begin
          pre_d   = '0;
          state_d = (count_q == '0) ? ST_DONE : ST_RUN;
        end
      end
      // HOLD resumes on the same edge pause drops, advancing from the frozen prescaler.
      ST_RUN, ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
          if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            count_d = dec_y;
            if (dec_y == '0) state_d = ST_DONE;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (!abort && reload_q != '0) begin
          state_d = ST_RUN;
          count_d = reload_q;
          pre_d   = '0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      pre_q   <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign done  = (state_q == ST_DONE);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign busy = (state_q == ST_RUN) || (state_q == ST_HOLD) ||
                ((state_q == ST_DONE) && (reload_q != '0));
`else
  assign busy = (state_q == ST_RUN) || (state_q == ST_HOLD);
`endif

endmodule
